// File: rtl/wasm_isa_pkg.sv
// Shared WASM ISA definitions for the fetch/decode stage: opcodes, immediate
// classes, FSM states and the decoded-instruction record.
package wasm_isa_pkg;

   localparam int LEB_MAX_BYTES_DEF = 5;

   localparam logic [7:0] OP_UNREACHABLE = 8'h00;
   localparam logic [7:0] OP_NOP         = 8'h01;
   localparam logic [7:0] OP_BLOCK       = 8'h02;
   localparam logic [7:0] OP_LOOP        = 8'h03;
   localparam logic [7:0] OP_IF          = 8'h04;
   localparam logic [7:0] OP_END         = 8'h0B;
   localparam logic [7:0] OP_BR          = 8'h0C;
   localparam logic [7:0] OP_BR_IF       = 8'h0D;
   localparam logic [7:0] OP_RETURN      = 8'h0F;
   localparam logic [7:0] OP_CALL        = 8'h10;
   localparam logic [7:0] OP_DROP        = 8'h1A;
   localparam logic [7:0] OP_SELECT      = 8'h1B;
   localparam logic [7:0] OP_LOCAL_GET   = 8'h20;
   localparam logic [7:0] OP_GLOBAL_SET  = 8'h24;
   localparam logic [7:0] OP_MEM_FIRST   = 8'h28;
   localparam logic [7:0] OP_MEM_LAST    = 8'h3E;
   localparam logic [7:0] OP_I32_CONST   = 8'h41;
   localparam logic [7:0] OP_NUM_FIRST   = 8'h45;
   localparam logic [7:0] OP_NUM_LAST    = 8'h78;

   typedef enum logic [2:0] {
      IC_NONE, IC_BLOCKTYPE, IC_ULEB, IC_SLEB, IC_MEMARG, IC_ILLEGAL
   } imm_class_e;

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH_OP, S_FETCH_IMM, S_FETCH_IMM2, S_OUT, S_HALT
   } state_e;

   typedef struct packed {
      logic [7:0]  opcode;
      logic [31:0] imm;
      logic [31:0] imm2;
      logic [31:0] pc;
      logic [31:0] next_pc;
      logic        illegal;
   } dec_t;

   function automatic imm_class_e classify(input logic [7:0] op);
      if (op inside {OP_UNREACHABLE, OP_NOP, OP_END, OP_RETURN, OP_DROP, OP_SELECT,
                     [OP_NUM_FIRST:OP_NUM_LAST]})                     return IC_NONE;
      if (op inside {OP_BLOCK, OP_LOOP, OP_IF})                         return IC_BLOCKTYPE;
      if (op inside {OP_BR, OP_BR_IF, OP_CALL, [OP_LOCAL_GET:OP_GLOBAL_SET]}) return IC_ULEB;
      if (op == OP_I32_CONST)                                           return IC_SLEB;
      if (op inside {[OP_MEM_FIRST:OP_MEM_LAST]})                       return IC_MEMARG;
      return IC_ILLEGAL;
   endfunction

endpackage

// File: rtl/wasm_fetch_decode_if.sv
// Byte-memory bus, decoded-instruction handshake and control inputs of the
// fetch/decode stage. master = decoder side, slave = memory/loader/execute side.
interface wasm_fetch_decode_if;
   logic        rom_mapped;
   logic [31:0] first_instruction;
   logic [31:0] mem_addr;
   logic        mem_read_en;
   logic [7:0]  mem_data_out;
   logic        mem_ready;
   logic        instr_valid;
   logic        instr_ready;
   logic [7:0]  instr_opcode;
   logic [31:0] instr_imm;
   logic [31:0] instr_imm2;
   logic [31:0] instr_pc;
   logic [31:0] instr_next_pc;
   logic        instr_illegal;
   logic        redirect_en;
   logic [31:0] redirect_pc;

   modport master (
      input  rom_mapped, first_instruction, mem_data_out, mem_ready, instr_ready,
             redirect_en, redirect_pc,
      output mem_addr, mem_read_en, instr_valid, instr_opcode, instr_imm, instr_imm2,
             instr_pc, instr_next_pc, instr_illegal
   );

   modport slave (
      output rom_mapped, first_instruction, mem_data_out, mem_ready, instr_ready,
             redirect_en, redirect_pc,
      input  mem_addr, mem_read_en, instr_valid, instr_opcode, instr_imm, instr_imm2,
             instr_pc, instr_next_pc, instr_illegal
   );
endinterface

// File: rtl/wasm_fetch_decode_leb128_acc.sv
// LEB128 accumulator: one byte per enable, signed/unsigned, self-clears once
// the value terminates or runs past MAX_BYTES.
module leb128_acc import wasm_isa_pkg::*; #(
   parameter int MAX_BYTES = LEB_MAX_BYTES_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        clr,
   input  logic        en,
   input  logic        is_signed,
   input  logic [7:0]  byte_in,
   output logic [31:0] value,
   output logic        done,
   output logic        ovf
);
   localparam int CW = $clog2(MAX_BYTES + 1);

   logic [31:0]   acc;
   logic [CW-1:0] cnt;
   logic [7:0]    sh_lo, sh_hi;

   // value is the accumulator including the byte presented this cycle
   always_comb begin
      sh_lo = 8'(cnt) * 8'd7;
      sh_hi = sh_lo + 8'd7;
      value = acc | (32'(byte_in[6:0]) << sh_lo);
      done  = en && !byte_in[7];
      ovf   = en && byte_in[7] && (cnt == CW'(MAX_BYTES - 1));
      if (is_signed && !byte_in[7] && byte_in[6] && (sh_hi < 8'd32))
         value = value | (32'hFFFF_FFFF << sh_hi);
   end

   always_ff @(posedge clk) begin
      if (rst || clr || done || ovf) begin
         acc <= '0;
         cnt <= '0;
      end else if (en) begin
         acc <= value;
         cnt <= cnt + 1'b1;
      end
   end
endmodule

// File: rtl/wasm_fetch_decode.sv
// WASM fetch/decode: one outstanding byte read, decodes opcode + immediates,
// presents one instruction at a time over valid/ready, honours PC redirects.
module wasm_fetch_decode import wasm_isa_pkg::*; #(
   parameter int LEB_MAX_BYTES = LEB_MAX_BYTES_DEF
) (
   input logic                 clk,
   input logic                 rst,
   wasm_fetch_decode_if.master bus
);
   state_e      state;
   imm_class_e  cls_q, cls_in;
   logic [31:0] pc, op_pc, align_q, leb_val;
   logic [7:0]  op_q;
   logic        rd_en, vld;
   dec_t        out_q, fin_dec;
   logic        ack, redir, fin, to_imm, to_imm2, leb_en, leb_done, leb_ovf;

   assign ack    = rd_en && bus.mem_ready;
   assign redir  = bus.redirect_en && (state != S_IDLE);
   assign cls_in = classify(bus.mem_data_out);
   // a byte landing together with a redirect is dropped, never accumulated
   assign leb_en = ack && !redir &&
                   (((state == S_FETCH_IMM) && (cls_q != IC_BLOCKTYPE)) || (state == S_FETCH_IMM2));

   leb128_acc #(.MAX_BYTES(LEB_MAX_BYTES)) u_leb (
      .clk       (clk),
      .rst       (rst),
      .clr       (redir),
      .en        (leb_en),
      .is_signed (cls_q == IC_SLEB),
      .byte_in   (bus.mem_data_out),
      .value     (leb_val),
      .done      (leb_done),
      .ovf       (leb_ovf)
   );

   // fin marks the final byte of an instruction; fin_dec is what OUT will show
   always_comb begin
      fin     = 1'b0;
      to_imm  = 1'b0;
      to_imm2 = 1'b0;
      fin_dec = '{opcode: op_q, imm: 32'd0, imm2: 32'd0, pc: op_pc,
                  next_pc: pc + 32'd1, illegal: 1'b0};
      if (ack) begin
         case (state)
            S_FETCH_OP: begin
               fin_dec.opcode  = bus.mem_data_out;
               fin_dec.pc      = pc;
               fin_dec.illegal = (cls_in == IC_ILLEGAL);
               fin             = (cls_in == IC_NONE) || (cls_in == IC_ILLEGAL);
               to_imm          = !fin;
            end
            S_FETCH_IMM: begin
               if (cls_q == IC_BLOCKTYPE) begin
                  fin         = 1'b1;
                  fin_dec.imm = {24'd0, bus.mem_data_out};
               end else if (leb_ovf) begin
                  fin             = 1'b1;
                  fin_dec.illegal = 1'b1;
               end else if (leb_done) begin
                  to_imm2     = (cls_q == IC_MEMARG);
                  fin         = (cls_q != IC_MEMARG);
                  fin_dec.imm = leb_val;
               end
            end
            S_FETCH_IMM2: begin
               if (leb_ovf) begin
                  fin             = 1'b1;
                  fin_dec.illegal = 1'b1;
               end else if (leb_done) begin
                  fin          = 1'b1;
                  fin_dec.imm  = leb_val;
                  fin_dec.imm2 = align_q;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IDLE;
         pc      <= '0;
         op_pc   <= '0;
         op_q    <= '0;
         cls_q   <= IC_NONE;
         align_q <= '0;
         rd_en   <= 1'b0;
         vld     <= 1'b0;
         out_q   <= '0;
      end else if (redir) begin
         state <= S_FETCH_OP;
         pc    <= bus.redirect_pc;
         rd_en <= 1'b1;
         vld   <= 1'b0;
      end else begin
         if (ack) pc <= pc + 32'd1;
         if (fin) begin
            out_q <= fin_dec;
            vld   <= 1'b1;
            rd_en <= 1'b0;
            state <= S_OUT;
         end
         case (state)
            S_IDLE: if (bus.rom_mapped) begin
               pc    <= bus.first_instruction;
               rd_en <= 1'b1;
               state <= S_FETCH_OP;
            end
            S_FETCH_OP: if (ack) begin
               op_q  <= bus.mem_data_out;
               op_pc <= pc;
               cls_q <= cls_in;
               if (to_imm) state <= S_FETCH_IMM;
            end
            S_FETCH_IMM: if (to_imm2) begin
               align_q <= leb_val;
               state   <= S_FETCH_IMM2;
            end
            // pc already points past the last immediate byte here
            S_OUT: if (bus.instr_ready) begin
               vld <= 1'b0;
               if (out_q.illegal) state <= S_HALT;
               else begin
                  rd_en <= 1'b1;
                  state <= S_FETCH_OP;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.mem_addr      = pc;
   assign bus.mem_read_en   = rd_en;
   assign bus.instr_valid   = vld;
   assign bus.instr_opcode  = out_q.opcode;
   assign bus.instr_imm     = out_q.imm;
   assign bus.instr_imm2    = out_q.imm2;
   assign bus.instr_pc      = out_q.pc;
   assign bus.instr_next_pc = out_q.next_pc;
   assign bus.instr_illegal = out_q.illegal;
endmodule

// File: tb/tb_wasm_fetch_decode.sv
// Directed bench for wasm_fetch_decode: table of byte sequences with expected
// decodes, plus hand sequences for hold, redirect and reset corner cases.
module tb_wasm_fetch_decode;
   typedef struct {
      logic [55:0] bytes;
      int          n;
      logic [7:0]  op;
      logic [31:0] imm;
      logic [31:0] imm2;
      logic [31:0] pc;
      logic [31:0] npc;
      logic        ill;
   } vec_t;

   localparam int NV = 7;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   wasm_fetch_decode_if bus();
   wasm_fetch_decode #(.LEB_MAX_BYTES(5)) dut (.clk(clk), .rst(rst), .bus(bus));

   int   n_chk = 0, n_fail = 0;
   vec_t tv[NV];
   logic [7:0] mem [256];
   int   m_cnt = 0, m_dly = 1;
   bit   rand_dly = 1'b0;

   // byte memory: mem_ready after m_dly cycles of mem_read_en, one-cycle pulse
   always @(negedge clk) begin
      if (rst || !bus.mem_read_en || bus.mem_ready) begin
         bus.mem_ready = 1'b0;
         m_cnt = 0;
      end else begin
         m_cnt++;
         if (m_cnt >= m_dly) begin
            bus.mem_ready    = 1'b1;
            bus.mem_data_out = mem[bus.mem_addr[7:0]];
            m_dly = rand_dly ? int'($urandom_range(5, 1)) : 1;
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic cyc1;
      @(posedge clk); #1;
   endtask

   task automatic wait_valid(input string name, output int cyc);
      cyc = 0;
      while (bus.instr_valid !== 1'b1 && cyc < 400) begin
         cyc1();
         cyc++;
      end
      chk({name, "_valid"}, 32'(bus.instr_valid), 32'd1);
   endtask

   task automatic chk_instr(input string name, input vec_t v);
      chk({name, "_op"}, 32'(bus.instr_opcode), 32'(v.op));
      if (!v.ill) begin
         chk({name, "_imm"},  bus.instr_imm,  v.imm);
         chk({name, "_imm2"}, bus.instr_imm2, v.imm2);
      end
      chk({name, "_pc"},  bus.instr_pc,      v.pc);
      chk({name, "_npc"}, bus.instr_next_pc, v.npc);
      chk({name, "_ill"}, 32'(bus.instr_illegal), 32'(v.ill));
   endtask

   task automatic consume(input string name);
      bus.instr_ready = 1'b1;
      cyc1();
      bus.instr_ready = 1'b0;
      chk({name, "_drop"}, 32'(bus.instr_valid), 32'd0);
   endtask

   task automatic redirect(input logic [31:0] tgt);
      bus.redirect_en = 1'b1;
      bus.redirect_pc = tgt;
      cyc1();
      bus.redirect_en = 1'b0;
   endtask

   task automatic chk_zero(input string name);
      chk({name, "_rd"},   32'(bus.mem_read_en), 32'd0);
      chk({name, "_addr"}, bus.mem_addr, 32'd0);
      chk({name, "_vld"},  32'(bus.instr_valid), 32'd0);
      chk({name, "_op"},   32'(bus.instr_opcode), 32'd0);
      chk({name, "_imm"},  bus.instr_imm, 32'd0);
      chk({name, "_imm2"}, bus.instr_imm2, 32'd0);
      chk({name, "_pc"},   bus.instr_pc, 32'd0);
      chk({name, "_npc"},  bus.instr_next_pc, 32'd0);
      chk({name, "_ill"},  32'(bus.instr_illegal), 32'd0);
   endtask

   task automatic halt_check(input string name);
      for (int k = 0; k < 8; k++) begin
         cyc1();
         chk({name, "_rd"}, 32'(bus.mem_read_en), 32'd0);
      end
      chk({name, "_vld"}, 32'(bus.instr_valid), 32'd0);
   endtask

   task automatic run_table(input string tag);
      int c;
      for (int i = 0; i < NV; i++) begin
         wait_valid($sformatf("%s%0d", tag, i), c);
         chk_instr($sformatf("%s%0d", tag, i), tv[i]);
         consume($sformatf("%s%0d", tag, i));
      end
   endtask

   task automatic sync_mem(input string name, input logic [31:0] addr);
      for (int k = 0; k < 200; k++) begin
         @(negedge clk); #1;
         if (bus.mem_ready && bus.mem_addr == addr) break;
      end
      chk(name, bus.mem_addr, addr);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      vec_t v;
      int   c;
      tv[0] = '{56'h7F41,           2, 8'h41, 32'hFFFF_FFFF, 32'h0,  32'h30, 32'h32, 1'b0};
      tv[1] = '{56'h268EE520,       4, 8'h20, 32'h0009_8765, 32'h0,  32'h32, 32'h36, 1'b0};
      tv[2] = '{56'h1A,             1, 8'h1A, 32'h0,         32'h0,  32'h36, 32'h37, 1'b0};
      tv[3] = '{56'h100228,         3, 8'h28, 32'h10,        32'h02, 32'h37, 32'h3A, 1'b0};
      tv[4] = '{56'h4002,           2, 8'h02, 32'h40,        32'h0,  32'h3A, 32'h3C, 1'b0};
      tv[5] = '{56'h7F8041,         3, 8'h41, 32'hFFFF_FF80, 32'h0,  32'h3C, 32'h3F, 1'b0};
      tv[6] = '{56'h80808080808010, 7, 8'h10, 32'h0,         32'h0,  32'h3F, 32'h45, 1'b1};

      for (int a = 0; a < 256; a++) mem[a] = 8'h00;
      for (int i = 0; i < NV; i++)
         for (int j = 0; j < tv[i].n; j++)
            mem[tv[i].pc[7:0] + 8'(j)] = tv[i].bytes[8*j +: 8];
      mem[8'h80] = 8'h20; mem[8'h81] = 8'h05;
      mem[8'h82] = 8'h41; mem[8'h83] = 8'h03;
      mem[8'h84] = 8'h01;
      mem[8'h90] = 8'h0B; mem[8'h91] = 8'hFF;

      bus.rom_mapped = 1'b0; bus.first_instruction = 32'h0;
      bus.mem_ready = 1'b0;  bus.mem_data_out = 8'h00;
      bus.instr_ready = 1'b0;
      bus.redirect_en = 1'b0; bus.redirect_pc = 32'h0;

      repeat (3) cyc1();
      chk_zero("reset");
      rst = 1'b0;
      cyc1();
      chk("idle_rd", 32'(bus.mem_read_en), 32'd0);

      // start: mem_read_en rises right after rom_mapped is sampled
      bus.rom_mapped = 1'b1;
      bus.first_instruction = 32'h30;
      cyc1();
      bus.rom_mapped = 1'b0;
      chk("start_rd", 32'(bus.mem_read_en), 32'd1);
      chk("start_addr", bus.mem_addr, 32'h30);
      wait_valid("first", c);
      chk("first_latency", 32'(c), 32'd3);

      // execute stage stalls: decode held, no new reads
      for (int k = 0; k < 10; k++) begin
         cyc1();
         chk("hold_vld", 32'(bus.instr_valid), 32'd1);
         chk("hold_rd",  32'(bus.mem_read_en), 32'd0);
         chk("hold_imm", bus.instr_imm, tv[0].imm);
         chk("hold_pc",  bus.instr_pc, tv[0].pc);
      end
      run_table("p1_");
      halt_check("halt1");

      // same program with random memory latency
      rand_dly = 1'b1;
      redirect(32'h30);
      run_table("p2_");
      halt_check("halt2");
      rand_dly = 1'b0;

      // redirect coinciding with mem_ready mid-LEB (0xE5 already accumulated)
      redirect(32'h32);
      sync_mem("rimm_sync", 32'h34);
      bus.redirect_en = 1'b1;
      bus.redirect_pc = 32'h80;
      cyc1();
      bus.redirect_en = 1'b0;
      chk("rimm_addr", bus.mem_addr, 32'h80);
      chk("rimm_rd",   32'(bus.mem_read_en), 32'd1);
      chk("rimm_vld",  32'(bus.instr_valid), 32'd0);
      v = '{56'h0520, 2, 8'h20, 32'd5, 32'd0, 32'h80, 32'h82, 1'b0};
      wait_valid("r80", c);
      chk_instr("r80", v);
      consume("r80");
      v = '{56'h0341, 2, 8'h41, 32'd3, 32'd0, 32'h82, 32'h84, 1'b0};
      wait_valid("r82", c);
      chk_instr("r82", v);

      // redirect together with instr_ready: redirect target wins
      bus.instr_ready = 1'b1;
      bus.redirect_en = 1'b1;
      bus.redirect_pc = 32'h90;
      cyc1();
      bus.instr_ready = 1'b0;
      bus.redirect_en = 1'b0;
      chk("rout_addr", bus.mem_addr, 32'h90);
      chk("rout_rd",   32'(bus.mem_read_en), 32'd1);
      chk("rout_vld",  32'(bus.instr_valid), 32'd0);
      v = '{56'h0B, 1, 8'h0B, 32'd0, 32'd0, 32'h90, 32'h91, 1'b0};
      wait_valid("r90", c);
      chk_instr("r90", v);
      consume("r90");
      v = '{56'hFF, 1, 8'hFF, 32'd0, 32'd0, 32'h91, 32'h92, 1'b1};
      wait_valid("rff", c);
      chk_instr("rff", v);
      consume("rff");
      halt_check("halt3");

      // reset in the middle of an LEB immediate
      redirect(32'h3F);
      sync_mem("rst_sync", 32'h42);
      rst = 1'b1;
      cyc1();
      chk_zero("rst_mid");
      rst = 1'b0;
      repeat (3) cyc1();
      chk("rst_idle_rd", 32'(bus.mem_read_en), 32'd0);
      bus.rom_mapped = 1'b1;
      bus.first_instruction = 32'h80;
      cyc1();
      bus.rom_mapped = 1'b0;
      v = '{56'h0520, 2, 8'h20, 32'd5, 32'd0, 32'h80, 32'h82, 1'b0};
      wait_valid("post_rst", c);
      chk_instr("post_rst", v);
      consume("post_rst");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
